// File: rtl/video_timing_pkg.sv
// Shared video timing constants for the
// pixel/line counter pipeline stages.
package video_timing_pkg;

  localparam int PIX_W  = 10;
  localparam int LINE_W = 10;

  // 640x480 VGA vertical timing
  localparam logic [LINE_W-1:0] V_TOTAL   = 10'd524;
  localparam logic [LINE_W-1:0] V_S_BLANK = 10'd480;
  localparam logic [LINE_W-1:0] V_R_BLANK = 10'd0;
  localparam logic [LINE_W-1:0] V_S_SYNC  = 10'd490;
  localparam logic [LINE_W-1:0] V_R_SYNC  = 10'd492;

  localparam bit SYNC_POL = 1'b1;

endpackage

// File: rtl/edge_flag.sv
// Set/clear flag with enable; a set match
// wins over a clear match on the same value.
module edge_flag #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] val,
  input  logic [W-1:0] set_val,
  input  logic [W-1:0] clr_val,
  output logic         flag
);

  always_ff @(posedge clk) begin
    if (rst) begin
      flag <= 1'b0;
    end else if (en) begin
      if (val == set_val) begin
        flag <= 1'b1;
      end else if (val == clr_val) begin
        flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/line_counter.sv
// Vertical timing stage: line count, vblank,
// vsync, frame start and display enable.
module line_counter
  import video_timing_pkg::*;
#(
  parameter int c           = LINE_W,
  parameter bit SYNC_ACTIVE = SYNC_POL
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         line_en,
  input  logic         h_blank,
  input  logic [c-1:0] total,
  input  logic [c-1:0] s_blank,
  input  logic [c-1:0] r_blank,
  input  logic [c-1:0] s_sync,
  input  logic [c-1:0] r_sync,
  output logic [c-1:0] q,
  output logic         blank,
  output logic         sync,
  output logic         frame_start,
  output logic         de
);

  logic [c-1:0] total_sh;
  logic [c-1:0] s_blank_sh;
  logic [c-1:0] r_blank_sh;
  logic [c-1:0] s_sync_sh;
  logic [c-1:0] r_sync_sh;
  logic [c-1:0] q_next;
  logic         wrap;
  logic         vs;

  always_comb begin
    wrap   = line_en && (q >= total_sh);
    q_next = q;
    if (wrap) begin
      q_next = '0;
    end else if (line_en) begin
      q_next = q + 1'b1;
    end
  end

  // Shadows reload only at frame boundaries
  always_ff @(posedge clk) begin
    if (rst) begin
      q           <= '0;
      frame_start <= 1'b0;
      de          <= 1'b0;
      total_sh    <= total;
      s_blank_sh  <= s_blank;
      r_blank_sh  <= r_blank;
      s_sync_sh   <= s_sync;
      r_sync_sh   <= r_sync;
    end else begin
      q           <= q_next;
      frame_start <= wrap;
      de          <= ~h_blank & ~blank;
      if (wrap) begin
        total_sh   <= total;
        s_blank_sh <= s_blank;
        r_blank_sh <= r_blank;
        s_sync_sh  <= s_sync;
        r_sync_sh  <= r_sync;
      end
    end
  end

  edge_flag #(.W(c)) u_blank (
    .clk     (clk),
    .rst     (rst),
    .en      (line_en),
    .val     (q_next),
    .set_val (s_blank_sh),
    .clr_val (r_blank_sh),
    .flag    (blank)
  );

  edge_flag #(.W(c)) u_vs (
    .clk     (clk),
    .rst     (rst),
    .en      (line_en),
    .val     (q_next),
    .set_val (s_sync_sh),
    .clr_val (r_sync_sh),
    .flag    (vs)
  );

  assign sync = vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;

endmodule

// File: tb/tb_line_counter.sv
// Self-checking bench for line_counter:
// directed tables, corner sequences, random.
module tb_line_counter;
  import video_timing_pkg::*;

  localparam int W = LINE_W;

  logic         clk = 1'b0;
  logic         rst;
  logic         line_en;
  logic         h_blank;
  logic [W-1:0] total;
  logic [W-1:0] s_blank;
  logic [W-1:0] r_blank;
  logic [W-1:0] s_sync;
  logic [W-1:0] r_sync;
  logic [W-1:0] q;
  logic         blank;
  logic         sync;
  logic         frame_start;
  logic         de;

  always #5 clk = ~clk;

  line_counter #(
    .c           (W),
    .SYNC_ACTIVE (SYNC_POL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .line_en     (line_en),
    .h_blank     (h_blank),
    .total       (total),
    .s_blank     (s_blank),
    .r_blank     (r_blank),
    .s_sync      (s_sync),
    .r_sync      (r_sync),
    .q           (q),
    .blank       (blank),
    .sync        (sync),
    .frame_start (frame_start),
    .de          (de)
  );

  int checks = 0;
  int errors = 0;

  // reference model state (frame-level view)
  int m_q, m_tot, m_sb, m_rb, m_ss, m_rs;
  bit m_blank, m_vs, m_fs, m_de;

  typedef struct {
    int line;
    bit blank;
    bit sync;
    bit fs;
  } vec_t;

  vec_t tbl[9];

  task automatic check(string name,
                       logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d",
               name, act, exp);
    end
  endtask

  task automatic load_sh();
    m_tot = int'(total);
    m_sb  = int'(s_blank);
    m_rb  = int'(r_blank);
    m_ss  = int'(s_sync);
    m_rs  = int'(r_sync);
  endtask

  // One line of the raster per accepted pulse
  task automatic model_step();
    int  nq;
    bit  wr;
    if (rst) begin
      m_q = 0; m_blank = 0; m_vs = 0;
      m_fs = 0; m_de = 0;
      load_sh();
    end else begin
      m_de = !h_blank && !m_blank;
      wr   = line_en && (m_q >= m_tot);
      m_fs = wr;
      if (line_en) begin
        nq = wr ? 0 : m_q + 1;
        if (nq == m_sb) m_blank = 1;
        else if (nq == m_rb) m_blank = 0;
        if (nq == m_ss) m_vs = 1;
        else if (nq == m_rs) m_vs = 0;
        m_q = nq;
      end
      if (wr) load_sh();
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("q", q, m_q);
    check("blank", blank, m_blank);
    check("sync", sync,
          m_vs ? SYNC_POL : !SYNC_POL);
    check("frame_start", frame_start, m_fs);
    check("de", de, m_de);
  endtask

  task automatic run_until_q(int t, int budget);
    int n = 0;
    while (int'(q) != t && n < budget) begin
      h_blank = 1'($urandom);
      cycle();
      n++;
    end
    check("reach_q", q, t);
  endtask

  task automatic set_vga();
    total   = V_TOTAL;
    s_blank = V_S_BLANK;
    r_blank = V_R_BLANK;
    s_sync  = V_S_SYNC;
    r_sync  = V_R_SYNC;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    line_en = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic sparse_line();
    bit prev;
    int qh;
    line_en = 1'b1;
    h_blank = 1'($urandom);
    cycle();
    line_en = 1'b0;
    qh = m_q;
    for (int k = 0; k < 799; k++) begin
      prev = 1'($urandom);
      h_blank = prev;
      cycle();
      check("sparse_hold", q, qh);
      check("sparse_de", de,
            (qh < 480) ? !prev : 1'b0);
    end
  endtask

  initial begin
    int fs_cnt;
    int lastq;

    tbl[0] = '{479, 0, 0, 0};
    tbl[1] = '{480, 1, 0, 0};
    tbl[2] = '{489, 1, 0, 0};
    tbl[3] = '{490, 1, 1, 0};
    tbl[4] = '{491, 1, 1, 0};
    tbl[5] = '{492, 1, 0, 0};
    tbl[6] = '{524, 1, 0, 0};
    tbl[7] = '{0,   0, 0, 1};
    tbl[8] = '{1,   0, 0, 0};

    rst = 1'b1;
    line_en = 1'b0;
    h_blank = 1'b0;
    total   = W'($urandom);
    s_blank = W'($urandom);
    r_blank = W'($urandom);
    s_sync  = W'($urandom);
    r_sync  = W'($urandom);

    // reset
    for (int i = 0; i < 3; i++) begin
      line_en = 1'($urandom);
      h_blank = 1'($urandom);
      cycle();
    end
    check("rst_q", q, 0);
    check("rst_blank", blank, 0);
    check("rst_sync", sync, 0);
    check("rst_fs", frame_start, 0);
    check("rst_de", de, 0);

    // full VGA frame, continuous enable
    set_vga();
    pulse_rst();
    line_en = 1'b1;
    foreach (tbl[i]) begin
      run_until_q(tbl[i].line, 1100);
      check("vga_blank", blank, tbl[i].blank);
      check("vga_sync", sync, tbl[i].sync);
      check("vga_fs", frame_start, tbl[i].fs);
    end
    fs_cnt = 0;
    for (int i = 0; i < 525; i++) begin
      h_blank = 1'($urandom);
      cycle();
      if (frame_start) fs_cnt++;
    end
    check("fs_per_525", fs_cnt, 1);

    // sparse enable
    for (int i = 0; i < 3; i++) sparse_line();
    line_en = 1'b1;
    run_until_q(478, 600);
    for (int i = 0; i < 4; i++) sparse_line();

    // mid-frame reprogram
    set_vga();
    pulse_rst();
    line_en = 1'b1;
    run_until_q(200, 300);
    total = 10'd99;
    for (int w = 0; w < 2; w++) begin
      lastq = -1;
      for (int n = 0; n < 600; n++) begin
        lastq = int'(q);
        cycle();
        if (frame_start) break;
      end
      check("fs_seen", frame_start, 1);
      check(w == 0 ? "wrap1_line" : "wrap2_line",
            lastq, w == 0 ? 524 : 99);
    end

    // reset mid-frame with line_en
    set_vga();
    pulse_rst();
    line_en = 1'b1;
    run_until_q(300, 400);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mrst_q", q, 0);
    check("mrst_blank", blank, 0);
    check("mrst_fs", frame_start, 0);

    // degenerate set == clear
    total   = 10'd60;
    s_sync  = 10'd10;
    r_sync  = 10'd10;
    s_blank = 10'd20;
    r_blank = 10'd20;
    pulse_rst();
    line_en = 1'b1;
    run_until_q(9, 100);
    check("deg_sync9", sync, 0);
    run_until_q(10, 100);
    check("deg_sync10", sync, 1);
    run_until_q(20, 100);
    check("deg_blank20", blank, 1);
    run_until_q(50, 100);
    check("deg_sync50", sync, 1);
    check("deg_blank50", blank, 1);
    run_until_q(5, 100);
    check("deg_sync_wrap", sync, 1);
    check("deg_blank_wrap", blank, 1);

    // randomized against the model
    total = 10'd30;
    pulse_rst();
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(99) == 0);
      line_en = ($urandom_range(2) != 0);
      h_blank = 1'($urandom);
      if ($urandom_range(49) == 0) begin
        total   = W'($urandom_range(5, 40));
        s_blank = W'($urandom_range(0, 45));
        r_blank = W'($urandom_range(0, 45));
        s_sync  = W'($urandom_range(0, 45));
        r_sync  = W'($urandom_range(0, 45));
      end
      cycle();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/line_counter.md
# line_counter

Vertical timing stage directly downstream of `pixel_counter`. It counts lines on the end-of-line pulse from the horizontal stage, generates vertical blank and sync from programmable edge values, and pulses at each frame start. It also combines horizontal and vertical blank into a registered display-enable for the pixel output stage. Configuration inputs are shadowed once per frame so that mid-frame reprogramming cannot tear the raster.

## Interface
- `c`, default 10: width of the line count and of every configuration input.
- `SYNC_ACTIVE`, default 1: level of `sync` inside the sync region. The output is `~SYNC_ACTIVE` outside it.
- `clk` in 1: the single clock. All state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `line_en` in 1: one-cycle pulse from the horizontal stage at the last pixel of each line.
- `h_blank` in 1: horizontal blank level from `pixel_counter`.
- `total` in c: index of the last line in the frame. Lines per frame = `total` + 1.
- `s_blank` in c: line on which vertical blank is set.
- `r_blank` in c: line on which vertical blank is cleared.
- `s_sync` in c: line on which the sync region starts.
- `r_sync` in c: line on which the sync region ends.
- `q` out c: current line number.
- `blank` out 1: vertical blank level.
- `sync` out 1: vertical sync, polarity set by `SYNC_ACTIVE`.
- `frame_start` out 1: one-cycle pulse when `q` wraps to 0.
- `de` out 1: display enable, registered `~h_blank & ~blank`.

## Operation
- **Shadow config:** `total`, `s_blank`, `r_blank`, `s_sync` and `r_sync` are copied into shadow registers on reset and on every wrap. All comparisons use the shadow copies only.
- **Counter:** `q_next` is computed as follows.
  - If `line_en` and `q >= total_sh`, then `q_next = 0` (a wrap).
  - Else if `line_en`, then `q_next = q + 1`.
  - Otherwise `q_next = q`.
  - The `>=` guard keeps `q` bounded.
- **Edge flags:** `blank` and `vs` (internal, active-high sync) are set/clear flops. They update only when `line_en` is high, by comparing `q_next` against the shadow set/clear values.
  - On a set-value match the flag goes to 1.
  - On a clear-value match it goes to 0.
  - If set and clear are equal, set wins. This configuration is degenerate, and the flag then stays at 1.
  - Edges that straddle the wrap work naturally, e.g. `r_blank` = 0 clears `blank` on the wrap.
- **Sync output:** `sync = vs ? SYNC_ACTIVE : ~SYNC_ACTIVE`.
- **Frame start:** `frame_start` is registered and equals 1 in the cycle after a wrap. It stays 0 after reset.
- **Display enable:** `de` is registered every cycle from the current `h_blank` and `blank`.

## Timing
- Reset values (next edge with `rst` high): `q` = 0, `blank` = 0, `vs` = 0 (so `sync` = `~SYNC_ACTIVE`), `frame_start` = 0, `de` = 0. Shadows take the current inputs.
- Reset has priority over `line_en` in the same cycle. A reset mid-frame restarts at line 0 with no `frame_start` pulse.
- Latencies:
  - `q`, `blank` and `sync` change on the edge where `line_en` is sampled high. They are aligned with each other, with no skew.
  - `frame_start` is high for exactly the cycle in which `q` first reads 0 after a wrap.
  - `de` lags `h_blank`/`blank` by 1 cycle.
- With `line_en` held high continuously, the block advances one line per cycle and must still be correct (this is the bench acceleration mode).
- New configuration becomes visible on the first line of the next frame, never mid-frame.

## Structure
- **Shared package** (`video_timing_pkg`):
  - Default width constants.
  - 640x480 VGA vertical constants: total 524, `s_blank` 480, `s_sync` 490, `r_sync` 492, `r_blank` 0.
  - The sync-polarity localparam.
- **Sub-module:** `edge_flag`, a parameterised set/clear flop with enable, set priority and synchronous reset. It is instantiated twice, for `blank` and `vs`. The same module is reusable for a later cleanup of the horizontal stage.
- **Counter, shadows, `frame_start` and `de`:** these live in the top level.

## Test plan
- **Reset:** hold `rst` 3 cycles with random config.
  - Expect `q` = 0, `blank` = 0, `sync` = 0 with `SYNC_ACTIVE` = 1, `frame_start` = 0, `de` = 0.
- **Full VGA frame:** use the package constants with `line_en` continuous.
  - `blank` rises when `q` = 480.
  - `sync` is high for `q` = 490..491.
  - `q` wraps 524→0 with `blank` clearing on that edge.
  - `frame_start` pulses once per 525 lines.
- **Sparse enable:** `line_en` once every 800 cycles.
  - `q` holds between pulses.
  - `de` follows `~h_blank` with 1-cycle lag while `q` < 480, and is 0 for `q` ≥ 480.
- **Mid-frame reprogram:** change `total` to 99 at `q` = 200.
  - The frame still wraps at 524.
  - The next frame wraps at 99, and `frame_start` marks both wraps.
- **Reset mid-frame:** assert `rst` at `q` = 300 coinciding with `line_en`.
  - `q` = 0 and `blank` = 0 on the next edge, with no `frame_start`.
- **Degenerate edges:** set `s_sync` = `r_sync` = 10.
  - `sync` asserts at `q` = 10 and stays asserted (set priority).
  - With `s_blank` = `r_blank`, `blank` likewise sticks at 1.
